// File: rtl/apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB3 bridge and its interconnect peers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_pkg;

    // Bridge FSM: LATCH is the first AHB data-phase cycle, ERR1/ERR2 form the two-cycle AHB ERROR.
    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } bridge_state_t;

    // AHB HTRANS encodings.
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Slot index of the UART inside the APB window.
    localparam logic [3:0] APB_UART_IDX = 4'hD;

endpackage

// File: rtl/apb_decoder.sv
// APB window decode: HADDR[31:12] -> {mapped, slot index}; shared with the AHB interconnect.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is used.
module apb_decoder #(
    parameter int          NUM_SLAVES = 16,
    parameter logic [15:0] APB_BASE   = 16'h4000
) (
    input  logic [31:12] haddr_i,
    output logic         mapped_o,
    output logic [3:0]   idx_o
);

    // Slot index is the 4 KB page inside the 64 KB window; it only maps if that slot exists.
    always_comb begin
        idx_o    = haddr_i[15:12];
        mapped_o = (haddr_i[31:16] == APB_BASE) && ({1'b0, haddr_i[15:12]} < 5'(NUM_SLAVES));
    end

endmodule

// File: rtl/apb_bridge_mc.sv
// AHB-Lite to APB3 bridge with one-hot PSEL decode, PREADY wait states, PSLVERR/timeout -> HRESP.
// Latency: 3 AHB wait states for a zero-wait APB slave, +1 per PREADY=0 cycle; unmapped = 2-cycle ERROR.
// Backpressure: one outstanding transfer; AHB is stalled via HREADYOUT until APB completes.
module apb_bridge_mc #(
    parameter int          NUM_SLAVES = 16,
    parameter int          DATA_W     = 32,
    parameter logic [15:0] APB_BASE   = 16'h4000,
    parameter int          TIMEOUT    = 255
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic                         HSEL,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    input  logic [DATA_W-1:0]            HWDATA,
    input  logic                         HREADY,
    output logic                         HREADYOUT,
    output logic                         HRESP,
    output logic [DATA_W-1:0]            HRDATA,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [31:0]                  PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    import apb_pkg::*;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // Last counter value at which a further PREADY=0 cycle forces the error, so PENABLE is
    // visible for exactly TIMEOUT ACCESS cycles before the bridge gives up.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    bridge_state_t           state_q, state_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;
    logic [DATA_W-1:0]       hrdata_q, hrdata_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [31:0]             paddr_q, paddr_d;
    logic [DATA_W-1:0]       pwdata_q, pwdata_d;
    logic [3:0]              idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    dec_mapped;
    logic [3:0]              dec_idx;
    logic                    accept;
    logic [15:0]             pready_ext;
    logic [15:0]             pslverr_ext;
    logic [15:0]             sel_onehot;
    logic [DATA_W-1:0]       prdata_sel;

    apb_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .APB_BASE   (APB_BASE)
    ) u_dec (
        .haddr_i  (HADDR[31:12]),
        .mapped_o (dec_mapped),
        .idx_o    (dec_idx)
    );

    // Widen per-slot handshakes to 16 so the latched 4-bit index can select without range issues.
    always_comb begin
        accept      = HSEL && HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
        pready_ext  = 16'(PREADY);
        pslverr_ext = 16'(PSLVERR);
        sel_onehot  = 16'h0001 << idx_q;
    end

    // Read-data mux for the active slot.
    always_comb begin
        prdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == 4'(i)) begin
                prdata_sel = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic for the bridge FSM.
    always_comb begin
        state_d     = state_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        hrdata_d    = hrdata_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    hreadyout_d = 1'b0;
                    if (dec_mapped) begin
                        // APB address/direction only move for transfers that reach a slave.
                        paddr_d  = HADDR;
                        pwrite_d = HWRITE;
                        idx_d    = dec_idx;
                        state_d  = LATCH;
                    end else begin
                        hresp_d = 1'b1;
                        state_d = ERR1;
                    end
                end
            end
            LATCH: begin
                // HWDATA is only valid now, one cycle after the address phase.
                if (pwrite_q) begin
                    pwdata_d = HWDATA;
                end
                psel_d  = sel_onehot[NUM_SLAVES-1:0];
                cnt_d   = '0;
                state_d = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready_ext[idx_q]) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (pslverr_ext[idx_q]) begin
                        hresp_d = 1'b1;
                        state_d = ERR1;
                    end else begin
                        if (!pwrite_q) begin
                            hrdata_d = prdata_sel;
                        end
                        hreadyout_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    hresp_d   = 1'b1;
                    state_d   = ERR1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR1: begin
                hreadyout_d = 1'b1;
                state_d     = ERR2;
            end
            ERR2: begin
                // The master is expected to cancel its next transfer on ERROR, so nothing is
                // accepted while ERR2 is showing.
                hresp_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                psel_d      = '0;
                penable_d   = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; asynchronous reset returns everything to the idle values.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            hrdata_q    <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            hrdata_q    <= hrdata_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = hrdata_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule
